axi_lite_cmd_master: RTL
========================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width; the strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit per AXI phase; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cmd_valid / cmd_ready, input / output, 1 each, command handshake.
REQ-007 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports cmd_addr (ADDR_WIDTH), cmd_wdata (DATA_WIDTH) and cmd_wstrb (DATA_WIDTH/8), all inputs, command payload.
REQ-009 SHALL have port rsp_valid / rsp_ready, output / input, 1 each, response handshake.
REQ-010 SHALL have outputs rsp_rdata (DATA_WIDTH), rsp_resp (2), rsp_write (1) and rsp_timeout (1).
REQ-011 SHALL have AXI4-Lite master ports axi_lite_awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid and rready, with directions mirroring the slave's.

Function
REQ-012 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-013 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, register the payload and enter WR_ADDR_DATA (write) or RD_ADDR (read) on the next cycle.
REQ-014 SHALL assert awvalid and wvalid together on entry to WR_ADDR_DATA, driving the registered addr/data/strb; each valid SHALL drop the cycle after its own handshake.
REQ-015 SHALL go to WR_RESP when both the AW and W handshakes are done, whether they complete in the same cycle or in either order.
REQ-016 SHALL hold bready=1 only in WR_RESP; on bvalid, capture bresp, set rsp_rdata=0 and rsp_write=1, then go to RESP.
REQ-017 SHALL hold arvalid=1 in RD_ADDR until arready; then enter RD_DATA with rready=1.
REQ-018 SHALL, on rvalid in RD_DATA, capture rdata and rresp, set rsp_write=0, then go to RESP.
REQ-019 SHALL hold rsp_valid=1 and keep all rsp_* stable in RESP until rsp_ready; then return to IDLE. There is no bypass: at least one cycle of rsp_valid per command.
REQ-020 SHALL clear the watchdog counter on entry to each AXI state and increment it every cycle while in that state.
REQ-021 SHALL, when the count reaches TIMEOUT_CYCLES (nonzero): deassert all AXI valid/ready outputs, set rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0, and go to RESP.
REQ-022 SHALL leave the payload, data and counter widths unchanged; the counter is clog2(TIMEOUT_CYCLES+1) bits and saturates.
REQ-023 SHALL ignore cmd_* outside IDLE; a command presented while the block is busy stays pending at the source.
REQ-024 SHALL, on simultaneous rvalid and timeout in the same cycle, give the handshake priority (rsp_timeout=0).

Reset
REQ-025 SHALL, on reset, go to IDLE and clear the watchdog counter.
REQ-026 SHALL drive these reset values: cmd_ready=0 during reset and 1 the cycle after; all AXI valid/ready outputs = 0; rsp_valid=0; rsp_* = 0.
REQ-027 SHALL, on reset mid-transaction, drop every AXI valid/ready on the next edge, with no response emitted.

Structure
REQ-028 SHALL take the state enum and response codes (OKAY 2'b00, SLVERR 2'b10) from the shared package axi_lite_pkg.
REQ-029 SHALL instantiate a single sub-module, axi_lite_watchdog, containing the counter with clear, enable and expired signals.

Verification
REQ-030 SHALL cover a write of addr 0x0, data 0x4, wstrb 0001, with awready and wready in the same cycle and bvalid 2 cycles later with bresp 00 -> rsp_valid, rsp_write=1, rsp_resp=00, rsp_timeout=0.
REQ-031 SHALL cover awready 3 cycles before wready -> awvalid drops after its handshake, wvalid is held until wready, and exactly one response follows.
REQ-032 SHALL cover a read of addr 0x0 with rdata 0x000000A5 and rresp 00 -> rsp_rdata=0xA5, rsp_write=0.
REQ-033 SHALL cover TIMEOUT_CYCLES=16 with arready held 0 -> arvalid drops after 16 cycles, rsp_timeout=1, rsp_resp=10.
REQ-034 SHALL cover rsp_ready held low for 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
REQ-035 SHALL cover reset asserted during WR_RESP -> all AXI outputs 0 next cycle and no rsp_valid.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared FSM state encoding and AXI4-Lite response codes
package axi_lite_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_watchdog.sv
// axi_lite_watchdog: per-phase cycle counter that flags when a phase has lasted LIMIT cycles
//   clk, reset : clock and synchronous active-high reset
//   i_clear    : zero the count (phase entry / not in an AXI phase)
//   i_enable   : count this cycle
//   o_expired  : this is the LIMIT-th cycle of the phase; 0 when LIMIT is 0
module axi_lite_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = LIMIT == 0 ? 1 : $clog2(LIMIT + 1);
  logic [CW-1:0] r_count;
  always_ff @(posedge clk)
    if (reset || i_clear) r_count <= '0;
    else if (i_enable && r_count != CW'(LIMIT)) r_count <= r_count + 1'b1;
  // Flag one cycle early so the count reaches LIMIT exactly on the edge that leaves the phase.
  assign o_expired = LIMIT != 0 && i_enable && r_count == CW'(LIMIT - 1);
endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: turns single read/write commands into AXI4-Lite transactions with a per-phase watchdog
//   clk, reset          : clock and synchronous active-high reset
//   cmd_*               : command handshake and payload (write flag, addr, wdata, wstrb)
//   rsp_*               : response handshake and result (rdata, resp, write flag, timeout flag)
//   axi_lite_*          : AXI4-Lite master channels AW, W, B, AR, R
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   axi_lite_awaddr,
  output logic                    axi_lite_awvalid,
  input  logic                    axi_lite_awready,
  output logic [DATA_WIDTH-1:0]   axi_lite_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_lite_wstrb,
  output logic                    axi_lite_wvalid,
  input  logic                    axi_lite_wready,
  input  logic [1:0]              axi_lite_bresp,
  input  logic                    axi_lite_bvalid,
  output logic                    axi_lite_bready,
  output logic [ADDR_WIDTH-1:0]   axi_lite_araddr,
  output logic                    axi_lite_arvalid,
  input  logic                    axi_lite_arready,
  input  logic [DATA_WIDTH-1:0]   axi_lite_rdata,
  input  logic [1:0]              axi_lite_rresp,
  input  logic                    axi_lite_rvalid,
  output logic                    axi_lite_rready
);
  state_t                  r_state;
  logic                    r_write, r_awvalid, r_wvalid;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic                    r_rsp_write, r_rsp_timeout;
  logic                    w_axi, w_hs, w_expired;
  assign w_axi = r_state inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
  // A write address/data phase is complete once each channel has either already handshaken or does so now.
  always_comb
    w_hs = r_state == WR_ADDR_DATA ? (!r_awvalid || axi_lite_awready) && (!r_wvalid || axi_lite_wready) :
           r_state == WR_RESP      ? axi_lite_bvalid :
           r_state == RD_ADDR      ? axi_lite_arready :
           r_state == RD_DATA      ? axi_lite_rvalid : 1'b0;
  axi_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_axi || w_hs),
    .i_enable  (w_axi),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_write   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_write   <= cmd_write;
          r_addr    <= cmd_addr;
          r_wdata   <= cmd_wdata;
          r_wstrb   <= cmd_wstrb;
          r_awvalid <= cmd_write;
          r_wvalid  <= cmd_write;
          r_state   <= cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
        WR_ADDR_DATA: begin
          if (axi_lite_awready) r_awvalid <= 1'b0;
          if (axi_lite_wready) r_wvalid <= 1'b0;
          if (w_hs) r_state <= WR_RESP;
        end
        WR_RESP: if (axi_lite_bvalid) begin
          r_rsp_rdata   <= '0;
          r_rsp_resp    <= axi_lite_bresp;
          r_rsp_write   <= 1'b1;
          r_rsp_timeout <= 1'b0;
          r_state       <= RESP;
        end
        RD_ADDR: if (axi_lite_arready) r_state <= RD_DATA;
        RD_DATA: if (axi_lite_rvalid) begin
          r_rsp_rdata   <= axi_lite_rdata;
          r_rsp_resp    <= axi_lite_rresp;
          r_rsp_write   <= 1'b0;
          r_rsp_timeout <= 1'b0;
          r_state       <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // A handshake in the expiring cycle wins; otherwise abandon the phase with an error response.
      if (w_axi && !w_hs && w_expired) begin
        r_awvalid     <= 1'b0;
        r_wvalid      <= 1'b0;
        r_rsp_rdata   <= '0;
        r_rsp_resp    <= RESP_SLVERR;
        r_rsp_write   <= r_write;
        r_rsp_timeout <= 1'b1;
        r_state       <= RESP;
      end
    end
  end
  assign cmd_ready        = r_state == IDLE && !reset;
  assign axi_lite_awaddr  = r_addr;
  assign axi_lite_awvalid = r_awvalid;
  assign axi_lite_wdata   = r_wdata;
  assign axi_lite_wstrb   = r_wstrb;
  assign axi_lite_wvalid  = r_wvalid;
  assign axi_lite_bready  = r_state == WR_RESP;
  assign axi_lite_araddr  = r_addr;
  assign axi_lite_arvalid = r_state == RD_ADDR;
  assign axi_lite_rready  = r_state == RD_DATA;
  assign rsp_valid        = r_state == RESP;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_resp         = r_rsp_resp;
  assign rsp_write        = r_rsp_write;
  assign rsp_timeout      = r_rsp_timeout;
endmodule
